computational_unit_param: RTL and testbench
===========================================

// Module: computational_unit_param
// PURPOSE
//  Next-generation datapath of the nibble-processor core: operand registers, ALU, index/modify
//  pair, output port and source bus, now width-parametrised. Multiply is a multi-cycle
//  shift-add engine with a busy handshake back to the program sequencer.
//  Sits between the instruction decoder (selects/enables) and data memory / I/O pins.
// PARAMETERS
//  DW       4   datapath width in bits (legal range 4..16)
//  MUL_CYC  DW  multiply iterations; fixed equal to DW, exposed only for the bench
// PORTS
//  clk           in   1      rising-edge clock
//  sync_reset    in   1      synchronous, active-high reset
//  ir_nibble     in   4      [3] alt-qualifier, [2:0] ALU function; also the pm_data immediate (zero-extended)
//  alternate_fn  in   1      selects alternate ALU table
//  source_sel    in   4      data_bus source: 0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 dm, 8 pm_data, 9 i_pins, 10-15 zero
//  reg_en        in   9      write enables: 0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 unused, 8 o_reg
//  i_sel         in   1      0: i<=data_bus, 1: i<=i+m
//  x_sel, y_sel  in   1      ALU operand selects (x0/x1, y0/y1)
//  dm, i_pins    in   DW     data memory read data, input pins
//  data_bus      out  DW     combinational source mux
//  x0,x1,y0,y1,r,m,i,o_reg  out DW  architectural registers
//  from_cu       out  2*DW   {x1,x0}
//  r_eq_0        out  1      zero flag of last r write
//  busy          out  1      multiply in progress; sequencer must stall
// BEHAVIOUR
//  - Reset: all DW registers <= 0, r_eq_0 <= 1, busy <= 0, FSM -> IDLE; reset wins over any enable, aborts multiply.
//  - Register writes: take effect on the edge where reg_en bit is 1; otherwise hold. Arithmetic modulo 2^DW.
//  - i+m wraps modulo 2^DW; no carry out.
//  - ALU (alternate_fn=0): 000 -x ([3]=0) / r ([3]=1); 001 x-y; 010 x+y; 011 mul high DW; 100 mul low DW;
//    101 x^y; 110 x&y; 111 ~x ([3]=0) / r ([3]=1). alternate_fn=1: 001 x-y+r, else r.
//  - Single-cycle ops: r and r_eq_0 updated on the edge with reg_en[4]=1.
//  - Multiply (fn 011/100, alternate_fn=0, reg_en[4]=1, IDLE): FSM IDLE->MUL; x,y and hi/lo select
//    latched; busy=1 from next cycle for exactly DW cycles; on the last MUL cycle r and r_eq_0 are written
//    with selected half of full 2*DW product; FSM returns to IDLE, busy=0 the following cycle.
//  - Latency: single-cycle ops 1 clock; multiply DW+1 clocks from request edge to r visible.
//  - While busy: reg_en[4] ignored (no new op, r not written); other registers still writable; changes to
//    x/y do not affect the in-flight product.
//  - r_eq_0 reflects the value written to r (full DW compare).
// CONFIGURATION
//  CU_MAC_EN defined: alternate_fn=1 with fn 011 = multiply-accumulate, r <= r + low(x*y), using the
//    multiply engine (same busy timing); r sampled at request edge.
//  CU_MAC_EN undefined: alternate_fn=1 fn 011 yields r (no write change); no accumulator adder built.
// STRUCTURE
//  Package cu_pkg: ALU function localparams (FN_NEG..FN_NOT), source_sel codes, reg_en bit indices,
//    FSM state typedef {IDLE, MUL}.
//  Sub-module cu_shift_add_mul (DW parameter; start, a, b -> busy, done, product[2*DW-1:0]).
//  Top: register file, source mux, ALU, zero flag, index adder.
// TESTING (DW=4 unless noted)
//  1 Reset: sync_reset=1 one edge with all reg_en=1 -> all registers 0, r_eq_0=1, busy=0.
//  2 Load x0=7,y0=5 via pm_data; fn 010 -> r=0xC, r_eq_0=0; fn 001 with x0=y0=5 -> r=0, r_eq_0=1.
//  3 Multiply x0=0xB,y0=0x7 fn 011 -> busy high 4 cycles, r=0x4 (0x4D); repeat fn 100 -> r=0xD.
//  4 During busy: pulse reg_en[4] with fn 010 and rewrite x0=0 -> ignored; result still 0x4; x0 reads 0.
//  5 Index: i=0xE, m=3, i_sel=1 two edges -> i=0x1 then 0x4 (wrap); sync_reset mid-multiply -> busy=0, r=0.
//  6 CU_MAC_EN, DW=8: r=0x10, x0=0x12,y0=0x10, alt fn 011 -> after 8 busy cycles r=0x30.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the nibble-processor computational unit.
// Holds the ALU function codes, the data_bus source codes, the reg_en bit
// indices and the multiply-engine state type.
// There are no ports. Every file that uses these definitions pulls them in
// with "import cu_pkg::*".
package cu_pkg;

    // ALU function codes (ir_nibble[2:0])
    localparam logic [2:0] FN_NEG  = 3'b000;
    localparam logic [2:0] FN_SUB  = 3'b001;
    localparam logic [2:0] FN_ADD  = 3'b010;
    localparam logic [2:0] FN_MULH = 3'b011;
    localparam logic [2:0] FN_MULL = 3'b100;
    localparam logic [2:0] FN_XOR  = 3'b101;
    localparam logic [2:0] FN_AND  = 3'b110;
    localparam logic [2:0] FN_NOT  = 3'b111;

    // data_bus source codes (source_sel)
    localparam logic [3:0] SRC_X0   = 4'd0;
    localparam logic [3:0] SRC_X1   = 4'd1;
    localparam logic [3:0] SRC_Y0   = 4'd2;
    localparam logic [3:0] SRC_Y1   = 4'd3;
    localparam logic [3:0] SRC_R    = 4'd4;
    localparam logic [3:0] SRC_M    = 4'd5;
    localparam logic [3:0] SRC_I    = 4'd6;
    localparam logic [3:0] SRC_DM   = 4'd7;
    localparam logic [3:0] SRC_PM   = 4'd8;
    localparam logic [3:0] SRC_PINS = 4'd9;

    // reg_en bit indices
    localparam int unsigned EN_X0    = 0;
    localparam int unsigned EN_X1    = 1;
    localparam int unsigned EN_Y0    = 2;
    localparam int unsigned EN_Y1    = 3;
    localparam int unsigned EN_R     = 4;
    localparam int unsigned EN_M     = 5;
    localparam int unsigned EN_I     = 6;
    localparam int unsigned EN_SPARE = 7;
    localparam int unsigned EN_O     = 8;

    typedef enum logic {IDLE, MUL} cu_state_t;

endpackage

// File: rtl/cu_shift_add_mul.sv
// Multi-cycle shift-add multiplier.
// Ports:
//   clk, sync_reset : clock and synchronous active-high reset
//   start           : accepted only while IDLE; latches a and b
//   a, b            : DW-bit unsigned operands
//   busy            : high for exactly CYC cycles after the start edge
//   done            : high during the last busy cycle
//   product         : full 2*DW product, valid while done is high
module cu_shift_add_mul
    import cu_pkg::*;
#(
    parameter int unsigned DW  = 4,
    parameter int unsigned CYC = DW
) (
    input  logic            clk,
    input  logic            sync_reset,
    input  logic            start,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic            busy,
    output logic            done,
    output logic [2*DW-1:0] product
);

    localparam int unsigned CW = $clog2(CYC + 1);

    cu_state_t       state, state_next;
    logic [2*DW-1:0] mcand, acc, acc_next;
    logic [DW-1:0]   mplier;
    logic [CW-1:0]   cnt;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                mcand  <= {{DW{1'b0}}, a};
                mplier <= b;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == MUL) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
        end
    end

    // The last partial product is added combinationally, so the caller can
    // capture the finished result on the same edge that leaves MUL.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        acc_next   = acc + (mplier[0] ? mcand : '0);
        case (state)
            IDLE: if (start) state_next = MUL;
            MUL: begin
                busy = 1'b1;
                if (cnt == CW'(CYC - 1)) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign product = acc_next;

endmodule

// File: rtl/computational_unit_param.sv
// Width-parametrised datapath of the nibble-processor core. It holds the
// operand registers, the ALU, the index/modify pair, the output port, the
// source bus and a multi-cycle multiplier with a busy handshake.
// Ports:
//   clk, sync_reset          : clock and synchronous active-high reset
//   ir_nibble[3:0]           : [3] alt-qualifier, [2:0] ALU function; also the pm_data immediate
//   alternate_fn             : selects the alternate ALU table
//   source_sel[3:0]          : data_bus source select
//   reg_en[8:0]              : per-register write enables
//   i_sel                    : 0 -> i<=data_bus, 1 -> i<=i+m
//   x_sel, y_sel             : ALU operand selects
//   dm, i_pins               : data memory read data, input pins
//   data_bus                 : combinational source mux
//   x0,x1,y0,y1,r,m,i,o_reg  : architectural registers
//   from_cu                  : {x1,x0}
//   r_eq_0                   : zero flag of the last r write
//   busy                     : multiply in progress
// Build option: defining CU_MAC_EN turns alternate_fn=1 / fn 011 into a
// multiply-accumulate.
module computational_unit_param
    import cu_pkg::*;
#(
    parameter int unsigned DW      = 4,
    parameter int unsigned MUL_CYC = DW
) (
    input  logic            clk,
    input  logic            sync_reset,
    input  logic [3:0]      ir_nibble,
    input  logic            alternate_fn,
    input  logic [3:0]      source_sel,
    input  logic [8:0]      reg_en,
    input  logic            i_sel,
    input  logic            x_sel,
    input  logic            y_sel,
    input  logic [DW-1:0]   dm,
    input  logic [DW-1:0]   i_pins,
    output logic [DW-1:0]   data_bus,
    output logic [DW-1:0]   x0,
    output logic [DW-1:0]   x1,
    output logic [DW-1:0]   y0,
    output logic [DW-1:0]   y1,
    output logic [DW-1:0]   r,
    output logic [DW-1:0]   m,
    output logic [DW-1:0]   i,
    output logic [DW-1:0]   o_reg,
    output logic [2*DW-1:0] from_cu,
    output logic            r_eq_0,
    output logic            busy
);

    logic [2:0]      fn;
    logic            qual;
    logic [DW-1:0]   pm_data, x, y, alu_res, mul_res, i_next;
    logic            is_mul_fn, is_mac_fn, mul_start, mul_busy, mul_done;
    logic            sel_hi;
    logic [2*DW-1:0] product;
    logic            unused_spare;

    assign fn           = ir_nibble[2:0];
    assign qual         = ir_nibble[3];
    assign pm_data      = DW'(ir_nibble);
    assign x            = x_sel ? x1 : x0;
    assign y            = y_sel ? y1 : y0;
    assign from_cu      = {x1, x0};
    assign busy         = mul_busy;
    assign unused_spare = reg_en[EN_SPARE];

    assign is_mul_fn = !alternate_fn && (fn == FN_MULH || fn == FN_MULL);
`ifdef CU_MAC_EN
    assign is_mac_fn = alternate_fn && (fn == FN_MULH);
`else
    assign is_mac_fn = 1'b0;
`endif
    assign mul_start = reg_en[EN_R] && !mul_busy && (is_mul_fn || is_mac_fn);

    cu_shift_add_mul #(.DW(DW), .CYC(MUL_CYC)) u_mul (
        .clk        (clk),
        .sync_reset (sync_reset),
        .start      (mul_start),
        .a          (x),
        .b          (y),
        .busy       (mul_busy),
        .done       (mul_done),
        .product    (product)
    );

    always_comb begin
        data_bus = '0;
        case (source_sel)
            SRC_X0:   data_bus = x0;
            SRC_X1:   data_bus = x1;
            SRC_Y0:   data_bus = y0;
            SRC_Y1:   data_bus = y1;
            SRC_R:    data_bus = r;
            SRC_M:    data_bus = m;
            SRC_I:    data_bus = i;
            SRC_DM:   data_bus = dm;
            SRC_PM:   data_bus = pm_data;
            SRC_PINS: data_bus = i_pins;
            default:  data_bus = '0;
        endcase
    end

    // Single-cycle ALU. The multiply codes fall through to r; they are
    // handled by the multiply engine.
    always_comb begin
        alu_res = r;
        if (alternate_fn) begin
            if (fn == FN_SUB) alu_res = x - y + r;
        end else begin
            case (fn)
                FN_NEG:  alu_res = qual ? r : -x;
                FN_SUB:  alu_res = x - y;
                FN_ADD:  alu_res = x + y;
                FN_XOR:  alu_res = x ^ y;
                FN_AND:  alu_res = x & y;
                FN_NOT:  alu_res = qual ? r : ~x;
                default: alu_res = r;
            endcase
        end
    end

`ifdef CU_MAC_EN
    logic mac_op;
    // r cannot be written while busy, so the r seen at the done edge equals
    // the r sampled at the request edge.
    assign mul_res = mac_op ? r + product[DW-1:0]
                            : (sel_hi ? product[2*DW-1:DW] : product[DW-1:0]);
    always_ff @(posedge clk) begin
        if (sync_reset)     mac_op <= 1'b0;
        else if (mul_start) mac_op <= is_mac_fn;
    end
`else
    assign mul_res = sel_hi ? product[2*DW-1:DW] : product[DW-1:0];
`endif

    assign i_next = i_sel ? i + m : data_bus;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            x0     <= '0;
            x1     <= '0;
            y0     <= '0;
            y1     <= '0;
            r      <= '0;
            m      <= '0;
            i      <= '0;
            o_reg  <= '0;
            r_eq_0 <= 1'b1;
            sel_hi <= 1'b0;
        end else begin
            if (reg_en[EN_X0]) x0    <= data_bus;
            if (reg_en[EN_X1]) x1    <= data_bus;
            if (reg_en[EN_Y0]) y0    <= data_bus;
            if (reg_en[EN_Y1]) y1    <= data_bus;
            if (reg_en[EN_M])  m     <= data_bus;
            if (reg_en[EN_I])  i     <= i_next;
            if (reg_en[EN_O])  o_reg <= data_bus;
            if (mul_done) begin
                r      <= mul_res;
                r_eq_0 <= (mul_res == '0);
            end else if (reg_en[EN_R] && !mul_busy && !mul_start) begin
                r      <= alu_res;
                r_eq_0 <= (alu_res == '0);
            end
            if (mul_start) sel_hi <= (fn == FN_MULH);
        end
    end

endmodule

// File: tb/tb_computational_unit_param.sv
// Self-checking bench for computational_unit_param (DW=4). It uses directed
// vector tables, hand-written multi-cycle sequences and randomized operations
// checked against a behavioural model. With CU_MAC_EN defined, a second DW=8
// instance exercises multiply-accumulate.
module tb_computational_unit_param;

    localparam int unsigned DW = 4;
`ifdef CU_MAC_EN
    localparam bit MAC = 1'b1;
`else
    localparam bit MAC = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            sync_reset, alternate_fn, i_sel, x_sel, y_sel;
    logic [3:0]      ir_nibble, source_sel;
    logic [8:0]      reg_en;
    logic [DW-1:0]   dm, i_pins;
    logic [DW-1:0]   data_bus, x0, x1, y0, y1, r, m, i, o_reg;
    logic [2*DW-1:0] from_cu;
    logic            r_eq_0, busy;

    computational_unit_param #(.DW(DW), .MUL_CYC(DW)) dut (
        .clk(clk), .sync_reset(sync_reset), .ir_nibble(ir_nibble),
        .alternate_fn(alternate_fn), .source_sel(source_sel), .reg_en(reg_en),
        .i_sel(i_sel), .x_sel(x_sel), .y_sel(y_sel), .dm(dm), .i_pins(i_pins),
        .data_bus(data_bus), .x0(x0), .x1(x1), .y0(y0), .y1(y1), .r(r), .m(m),
        .i(i), .o_reg(o_reg), .from_cu(from_cu), .r_eq_0(r_eq_0), .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model of the architectural state
    logic [DW-1:0] mx0, mx1, my0, my1, mr, mm, mi, mo;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mx0 = '0; mx1 = '0; my0 = '0; my1 = '0; mr = '0; mm = '0; mi = '0; mo = '0;
    endtask

    task automatic load(input int unsigned idx, input logic [DW-1:0] v);
        source_sel = 4'd7;
        dm         = v;
        i_sel      = 1'b0;
        reg_en     = 9'(1 << idx);
        tick();
        reg_en = '0;
        case (idx)
            0: mx0 = v;
            1: mx1 = v;
            2: my0 = v;
            3: my1 = v;
            5: mm  = v;
            6: mi  = v;
            8: mo  = v;
            default: ;
        endcase
    endtask

    // Result of an ALU request, computed from the function table with integer arithmetic.
    function automatic logic [DW-1:0] ref_alu(input logic [3:0] nib, input logic alt,
                                             input logic [DW-1:0] xv, yv, rv);
        int xi, yi, ri, prod, res, mask;
        xi   = int'(xv);
        yi   = int'(yv);
        ri   = int'(rv);
        prod = xi * yi;
        mask = (1 << DW) - 1;
        if (alt) begin
            if (nib[2:0] == 3'd1)             res = xi - yi + ri;
            else if (MAC && nib[2:0] == 3'd3) res = ri + prod;
            else                              res = ri;
        end else begin
            case (nib[2:0])
                3'd0: res = nib[3] ? ri : -xi;
                3'd1: res = xi - yi;
                3'd2: res = xi + yi;
                3'd3: res = prod >> DW;
                3'd4: res = prod;
                3'd5: res = xi ^ yi;
                3'd6: res = xi & yi;
                default: res = nib[3] ? ri : ~xi;
            endcase
        end
        return DW'(res & mask);
    endfunction

    // Issue one r-write request and follow it to completion, checking busy timing.
    task automatic do_op(input logic [3:0] nib, input logic alt, input logic xs, input logic ys);
        logic [DW-1:0] xv, yv, expr;
        logic          multi;
        xv    = xs ? mx1 : mx0;
        yv    = ys ? my1 : my0;
        expr  = ref_alu(nib, alt, xv, yv, mr);
        multi = (!alt && (nib[2:0] == 3'd3 || nib[2:0] == 3'd4)) || (MAC && alt && nib[2:0] == 3'd3);
        ir_nibble = nib; alternate_fn = alt; x_sel = xs; y_sel = ys;
        reg_en = 9'h010;
        tick();
        reg_en = '0;
        if (multi) begin
            for (int k = 0; k < int'(DW); k++) begin
                check("busy_during_mul", 32'(busy), 32'd1);
                check("r_hold_during_mul", 32'(r), 32'(mr));
                tick();
            end
        end
        check("busy_idle", 32'(busy), 32'd0);
        mr = expr;
        check("r_model", 32'(r), 32'(mr));
        check("r_eq_0_model", 32'(r_eq_0), 32'(mr == '0));
    endtask

    typedef struct {
        logic [3:0]    nib;
        logic          alt;
        logic [DW-1:0] xv;
        logic [DW-1:0] yv;
        logic [DW-1:0] er;
    } vec_t;
    vec_t tbl[17];

`ifdef CU_MAC_EN
    logic            rst8, alt8, isel8, xsel8, ysel8, req8, busy8, z8;
    logic [3:0]      nib8, src8;
    logic [8:0]      en8;
    logic [7:0]      dm8, pins8, bus8, x08, x18, y08, y18, r8, m8, i8, o8;
    logic [15:0]     fcu8;

    computational_unit_param #(.DW(8), .MUL_CYC(8)) dut8 (
        .clk(clk), .sync_reset(rst8), .ir_nibble(nib8), .alternate_fn(alt8),
        .source_sel(src8), .reg_en(en8), .i_sel(isel8), .x_sel(xsel8), .y_sel(ysel8),
        .dm(dm8), .i_pins(pins8), .data_bus(bus8), .x0(x08), .x1(x18), .y0(y08),
        .y1(y18), .r(r8), .m(m8), .i(i8), .o_reg(o8), .from_cu(fcu8),
        .r_eq_0(z8), .busy(busy8)
    );
    assign req8 = 1'b0;
`endif

    initial begin
        int unsigned   pick_tbl[6];
        logic [DW-1:0] exp_bus;

        tbl[0]  = '{4'h2, 1'b0, 4'h7, 4'h5, 4'hC};
        tbl[1]  = '{4'h1, 1'b0, 4'h5, 4'h5, 4'h0};
        tbl[2]  = '{4'h0, 1'b0, 4'h3, 4'h0, 4'hD};
        tbl[3]  = '{4'h8, 1'b0, 4'h9, 4'h0, 4'hD};
        tbl[4]  = '{4'h5, 1'b0, 4'h6, 4'h3, 4'h5};
        tbl[5]  = '{4'h6, 1'b0, 4'h6, 4'h3, 4'h2};
        tbl[6]  = '{4'h7, 1'b0, 4'h6, 4'h3, 4'h9};
        tbl[7]  = '{4'hF, 1'b0, 4'h6, 4'h3, 4'h9};
        tbl[8]  = '{4'h1, 1'b1, 4'h6, 4'h3, 4'hC};
        tbl[9]  = '{4'h2, 1'b1, 4'h6, 4'h3, 4'hC};
        tbl[10] = '{4'h5, 1'b1, 4'h0, 4'h0, 4'hC};
        tbl[11] = '{4'h1, 1'b0, 4'h0, 4'h1, 4'hF};
        tbl[12] = '{4'h2, 1'b0, 4'hF, 4'h1, 4'h0};
        tbl[13] = '{4'h3, 1'b0, 4'hB, 4'h7, 4'h4};
        tbl[14] = '{4'h4, 1'b0, 4'hB, 4'h7, 4'hD};
        tbl[15] = '{4'h3, 1'b0, 4'hF, 4'hF, 4'hE};
        tbl[16] = '{4'h4, 1'b0, 4'hF, 4'hF, 4'h1};
        pick_tbl = '{0, 1, 2, 3, 5, 6};

        sync_reset = 1'b1; ir_nibble = '0; alternate_fn = 1'b0; source_sel = 4'd15;
        reg_en = '0; i_sel = 1'b0; x_sel = 1'b0; y_sel = 1'b0; dm = '0; i_pins = '0;
`ifdef CU_MAC_EN
        rst8 = 1'b1; nib8 = '0; alt8 = 1'b0; src8 = 4'd7; en8 = '0; isel8 = 1'b0;
        xsel8 = 1'b0; ysel8 = 1'b0; dm8 = '0; pins8 = '0;
`endif
        tick();
        sync_reset = 1'b0;
        model_reset();

        // reset wins over every enable
        load(0, 4'h3); load(1, 4'h4); load(2, 4'h5); load(3, 4'h6);
        load(5, 4'h7); load(6, 4'h8); load(8, 4'h9);
        do_op(4'h2, 1'b0, 1'b0, 1'b0);
        sync_reset = 1'b1; reg_en = '1; source_sel = 4'd8; ir_nibble = 4'hF;
        tick();
        sync_reset = 1'b0; reg_en = '0;
        model_reset();
        check("rst_x0", 32'(x0), 0); check("rst_x1", 32'(x1), 0);
        check("rst_y0", 32'(y0), 0); check("rst_y1", 32'(y1), 0);
        check("rst_r", 32'(r), 0);   check("rst_m", 32'(m), 0);
        check("rst_i", 32'(i), 0);   check("rst_o", 32'(o_reg), 0);
        check("rst_r_eq_0", 32'(r_eq_0), 1);
        check("rst_busy", 32'(busy), 0);

        // directed ALU vectors
        for (int k = 0; k < 17; k++) begin
            load(0, tbl[k].xv);
            load(2, tbl[k].yv);
            do_op(tbl[k].nib, tbl[k].alt, 1'b0, 1'b0);
            check($sformatf("tbl%0d_r", k), 32'(r), 32'(tbl[k].er));
            check($sformatf("tbl%0d_z", k), 32'(r_eq_0), 32'(tbl[k].er == '0));
        end

        // alternate fn 011: accumulate or plain r, depending on build (r is 1 here)
        load(0, 4'h2); load(2, 4'h3);
        do_op(4'h3, 1'b1, 1'b0, 1'b0);
`ifdef CU_MAC_EN
        check("alt011_r", 32'(r), 32'h7);
`else
        check("alt011_r", 32'(r), 32'h1);
`endif

        // source mux and output port
        load(0, 4'h1); load(1, 4'h2); load(2, 4'h3); load(3, 4'h4); load(5, 4'h5); load(6, 4'hE);
        dm = 4'hA; i_pins = 4'h9; ir_nibble = 4'h6;
        for (int s = 0; s < 16; s++) begin
            source_sel = 4'(s);
            #1;
            case (s)
                0: exp_bus = mx0;  1: exp_bus = mx1;  2: exp_bus = my0;  3: exp_bus = my1;
                4: exp_bus = mr;   5: exp_bus = mm;   6: exp_bus = mi;   7: exp_bus = 4'hA;
                8: exp_bus = 4'h6; 9: exp_bus = 4'h9; default: exp_bus = '0;
            endcase
            check($sformatf("bus_sel%0d", s), 32'(data_bus), 32'(exp_bus));
        end
        source_sel = 4'd9; reg_en = 9'h100;
        tick();
        reg_en = '0; mo = 4'h9;
        check("o_reg_pins", 32'(o_reg), 32'h9);
        check("from_cu", 32'(from_cu), 32'h21);

        // writes during busy: r request ignored, x0 rewrite lands, product unaffected
        load(0, 4'hB); load(2, 4'h7);
        ir_nibble = 4'h3; alternate_fn = 1'b0; x_sel = 1'b0; y_sel = 1'b0; reg_en = 9'h010;
        tick();
        check("busy_start", 32'(busy), 1);
        ir_nibble = 4'h2; source_sel = 4'd7; dm = 4'h0; reg_en = 9'h011;
        tick();
        reg_en = '0; mx0 = 4'h0;
        check("busy_x0_written", 32'(x0), 0);
        check("busy_still", 32'(busy), 1);
        repeat (DW - 1) tick();
        mr = 4'h4;
        check("busy_done", 32'(busy), 0);
        check("busy_ignore_r", 32'(r), 32'h4);
        check("busy_ignore_z", 32'(r_eq_0), 0);

        // index wrap
        load(5, 4'h3); load(6, 4'hE);
        i_sel = 1'b1; reg_en = 9'h040;
        tick();
        check("index_wrap1", 32'(i), 32'h1);
        tick();
        check("index_wrap2", 32'(i), 32'h4);
        reg_en = '0; i_sel = 1'b0; mi = 4'h4;

        // reset in the middle of a multiply
        load(0, 4'hB); load(2, 4'h7);
        ir_nibble = 4'h4; reg_en = 9'h010;
        tick();
        reg_en = '0;
        tick();
        sync_reset = 1'b1;
        tick();
        sync_reset = 1'b0;
        model_reset();
        check("abort_busy", 32'(busy), 0);
        check("abort_r", 32'(r), 0);
        check("abort_z", 32'(r_eq_0), 1);
        repeat (DW) tick();
        check("abort_no_late_write", 32'(r), 0);
        check("abort_busy_later", 32'(busy), 0);

        // randomized operations against the model
        for (int n = 0; n < 300; n++) begin
            int unsigned pick;
            pick = pick_tbl[$urandom_range(0, 5)];
            if (pick == 6 && $urandom_range(0, 1) == 1) begin
                i_sel = 1'b1; reg_en = 9'h040;
                tick();
                reg_en = '0; i_sel = 1'b0;
                mi = mi + mm;
                check("rand_index", 32'(i), 32'(mi));
            end else begin
                load(pick, DW'($urandom));
            end
            do_op(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        check("rand_x0", 32'(x0), 32'(mx0));
        check("rand_y1", 32'(y1), 32'(my1));

`ifdef CU_MAC_EN
        // multiply-accumulate at DW=8
        tick();
        rst8 = 1'b0;
        src8 = 4'd7; dm8 = 8'h10; en8 = 9'h001; tick();
        dm8 = 8'h00; en8 = 9'h004; tick();
        nib8 = 4'h2; alt8 = 1'b0; en8 = 9'h010; tick();
        en8 = '0;
        check("mac8_r_init", 32'(r8), 32'h10);
        dm8 = 8'h12; en8 = 9'h001; tick();
        dm8 = 8'h10; en8 = 9'h004; tick();
        nib8 = 4'h3; alt8 = 1'b1; en8 = 9'h010; tick();
        en8 = '0;
        for (int k = 0; k < 8; k++) begin
            check("mac8_busy", 32'(busy8), 1);
            tick();
        end
        check("mac8_busy_end", 32'(busy8), 0);
        check("mac8_r", 32'(r8), 32'h30);
        check("mac8_z", 32'(z8), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
